// File: rtl/multicycle_datapath.sv
// multicycle_datapath: MIPS-subset core whose datapath and control FSM share
// one block. Each instruction runs over 3-5 states and uses a single
// req/ack memory port for both instruction fetch and data access.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      pc_out,
  output logic [2:0]       state_out,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMACC = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  state_t           state, next_state;
  logic [31:0]      pc, ir, reg_a, reg_b, alu_out, mdr;
  logic [31:0]      gpr [32];
  logic [CNT_W-1:0] cnt;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, branch_target, jump_target, alu_result;
  logic        legal;
  logic        req_raw, we_raw, retire_raw;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  assign opcode        = ir[31:26];
  assign rs            = ir[25:21];
  assign rt            = ir[20:16];
  assign rd            = ir[15:11];
  assign funct         = ir[5:0];
  assign imm_sext      = {{16{ir[15]}}, ir[15:0]};
  assign branch_target = pc + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc[31:28], ir[25:0], 2'b00};

  // Decide whether the fetched instruction belongs to the supported subset
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_SLT);
      OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // ALU: R-type operations, otherwise base plus sign-extended immediate
  always_comb begin
    alu_result = reg_a + imm_sext;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  alu_result = reg_a + reg_b;
        FN_SUB:  alu_result = reg_a - reg_b;
        FN_AND:  alu_result = reg_a & reg_b;
        FN_OR:   alu_result = reg_a | reg_b;
        FN_SLT:  alu_result = {31'd0, ($signed(reg_a) < $signed(reg_b))};
        default: alu_result = reg_a + reg_b;
      endcase
    end
  end

  // Write-back destination and source; register 0 means no write
  always_comb begin
    wb_dst  = 5'd0;
    wb_data = alu_out;
    case (opcode)
      OP_RTYPE: wb_dst = rd;
      OP_ADDI:  wb_dst = rt;
      OP_LW: begin
        wb_dst  = rt;
        wb_data = mdr;
      end
      default: wb_dst = 5'd0;
    endcase
  end

  // Control: next state, memory request signals and retire strobe
  always_comb begin
    next_state = state;
    req_raw    = 1'b0;
    we_raw     = 1'b0;
    mem_addr   = pc;
    mem_wdata  = 32'd0;
    retire_raw = 1'b0;
    case (state)
      FETCH: begin
        req_raw = 1'b1;
        if (mem_ack) next_state = DECODE;
      end
      DECODE: next_state = legal ? EXEC : TRAP;
      EXEC: begin
        case (opcode)
          OP_LW, OP_SW: next_state = (alu_result[1:0] != 2'b00) ? TRAP : MEMACC;
          OP_BEQ, OP_BNE, OP_J: begin
            next_state = FETCH;
            retire_raw = 1'b1;
          end
          OP_RTYPE, OP_ADDI: next_state = WB;
          default: next_state = TRAP;
        endcase
      end
      MEMACC: begin
        req_raw  = 1'b1;
        mem_addr = alu_out;
        if (opcode == OP_SW) begin
          we_raw    = 1'b1;
          mem_wdata = reg_b;
        end
        if (mem_ack) begin
          if (opcode == OP_SW) begin
            next_state = FETCH;
            retire_raw = 1'b1;
          end else begin
            next_state = WB;
          end
        end
      end
      WB: begin
        next_state = FETCH;
        retire_raw = 1'b1;
      end
      TRAP: next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  // Reset masks the bus immediately so an ack during reset cannot commit a store
  assign mem_req       = req_raw & rst;
  assign mem_we        = we_raw & rst;
  assign instr_retired = retire_raw & rst;
  assign halted        = (state == TRAP);
  assign pc_out        = pc;
  assign state_out     = state;
  assign retire_cnt    = cnt;

  // State register; TRAP is left only through reset
  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= next_state;
  end

  // Datapath registers updated according to the current state
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      reg_a   <= 32'd0;
      reg_b   <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          reg_a   <= gpr[rs];
          reg_b   <= gpr[rt];
          alu_out <= branch_target;
        end
        EXEC: begin
          case (opcode)
            OP_BEQ:  if (reg_a == reg_b) pc <= alu_out;
            OP_BNE:  if (reg_a != reg_b) pc <= alu_out;
            OP_J:    pc <= jump_target;
            default: alu_out <= alu_result;
          endcase
        end
        MEMACC: begin
          if (mem_ack && (opcode == OP_LW)) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Register file: cleared on reset, written only in WB, register 0 never written
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else if ((state == WB) && (wb_dst != 5'd0)) begin
      gpr[wb_dst] <= wb_data;
    end
  end

  // Retired-instruction counter, wrapping naturally at all-ones
  always_ff @(posedge clk) begin
    if (!rst)               cnt <= '0;
    else if (instr_retired) cnt <= cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed and randomized programs run on the core
// against an instruction-level reference interpreter and a wait-state memory.
module tb_multicycle_datapath;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          PBASE    = 64;

  logic        clk;
  logic        rst, rst4;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pc_out;
  logic [2:0]  state_out;
  logic        instr_retired, halted;
  logic [31:0] retire_cnt;

  logic        req4, we4, ret4, halt4;
  logic        ack4;
  logic [31:0] addr4, wdata4, rdata4, pc4;
  logic [2:0]  st4;
  logic [3:0]  cnt4;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] mem [0:255];
  logic [31:0] mm  [0:255];
  logic [31:0] rf  [0:31];
  logic [31:0] exp_wa[$], exp_wd[$], dut_wa[$], dut_wd[$];
  logic [31:0] exp_pc;
  int          exp_cnt;
  bit          exp_trap;

  int          pulses;
  int          fixed_wait = -1;
  int          max_wait   = 0;
  bit          busy;
  int          wait_left;
  logic [31:0] req_addr, req_wdata;
  logic        req_we;
  int          slot;

  assign ack4   = 1'b1;
  assign rdata4 = 32'h0800_0000;

  multicycle_datapath #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_out(pc_out),
    .state_out(state_out), .instr_retired(instr_retired), .retire_cnt(retire_cnt),
    .halted(halted)
  );

  multicycle_datapath #(.RESET_PC(32'h0), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .mem_req(req4), .mem_we(we4), .mem_addr(addr4),
    .mem_wdata(wdata4), .mem_rdata(rdata4), .mem_ack(ack4), .pc_out(pc4),
    .state_out(st4), .instr_retired(ret4), .retire_cnt(cnt4), .halted(halt4)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic fill_memory();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    slot = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    mem[PBASE + slot] = w;
    slot++;
  endtask

  task automatic emit_halt();
    emit(enc_j(RESET_PC + 32'(slot * 4)));
  endtask

  // Instruction-level interpreter of the program image in mm[]
  task automatic model_run();
    logic [31:0] pc, ins, cur, imm, res, ea, tgt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, dst;
    bit          done, wr;
    pc = RESET_PC; exp_cnt = 0; exp_trap = 0; done = 0;
    exp_wa.delete(); exp_wd.delete();
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    for (int step = 0; step < 5000 && !done; step++) begin
      ins = mm[pc[9:2]]; cur = pc; pc = pc + 32'd4;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
      imm = {{16{ins[15]}}, ins[15:0]};
      wr = 0; dst = 5'd0; res = 32'd0;
      case (op)
        6'h00: begin
          wr = 1; dst = rd;
          case (fn)
            6'h20: res = rf[rs] + rf[rt];
            6'h22: res = rf[rs] - rf[rt];
            6'h24: res = rf[rs] & rf[rt];
            6'h25: res = rf[rs] | rf[rt];
            6'h2A: res = ($signed(rf[rs]) < $signed(rf[rt])) ? 32'd1 : 32'd0;
            default: begin exp_trap = 1; wr = 0; end
          endcase
        end
        6'h08: begin wr = 1; dst = rt; res = rf[rs] + imm; end
        6'h23: begin
          ea = rf[rs] + imm;
          if (ea[1:0] != 2'b00) exp_trap = 1;
          else begin wr = 1; dst = rt; res = mm[ea[9:2]]; end
        end
        6'h2B: begin
          ea = rf[rs] + imm;
          if (ea[1:0] != 2'b00) exp_trap = 1;
          else begin
            mm[ea[9:2]] = rf[rt];
            exp_wa.push_back(ea); exp_wd.push_back(rf[rt]);
          end
        end
        6'h04: if (rf[rs] == rf[rt]) pc = pc + (imm << 2);
        6'h05: if (rf[rs] != rf[rt]) pc = pc + (imm << 2);
        6'h02: begin
          tgt = {pc[31:28], ins[25:0], 2'b00};
          if (tgt == cur) done = 1;
          pc = tgt;
        end
        default: exp_trap = 1;
      endcase
      if (exp_trap) done = 1;
      else begin
        if (wr && dst != 5'd0) rf[dst] = res;
        exp_cnt++;
      end
    end
    exp_pc = pc;
  endtask

  task automatic holdReset();
    rst = 1'b0;
    tick(2);
  endtask

  // Compute expectations from the loaded image, then release reset
  task automatic applyStimulus(input string tag);
    $display("[TB] running %s", tag);
    for (int i = 0; i < 256; i++) mm[i] = mem[i];
    model_run();
    dut_wa.delete(); dut_wd.delete();
    pulses = 0;
    rst = 1'b1;
  endtask

  // Run to the end of the program (or trap) and compare with the model
  task automatic finishRun(input string tag, input int budget);
    int n;
    n = 0;
    if (!exp_trap) begin
      while (pulses < exp_cnt && n < budget) begin tick(1); n++; end
      checkOutput({tag, " finished"}, 32'(pulses >= exp_cnt), 32'd1);
      checkOutput({tag, " halted"}, {31'd0, halted}, 32'd0);
    end else begin
      while (halted !== 1'b1 && n < budget) begin tick(1); n++; end
      checkOutput({tag, " halted"}, {31'd0, halted}, 32'd1);
      checkOutput({tag, " state"}, {29'd0, state_out}, 32'd7);
      repeat (20) begin
        tick(1);
        checkOutput({tag, " trap req"}, {31'd0, mem_req}, 32'd0);
        checkOutput({tag, " trap cnt"}, retire_cnt, 32'(exp_cnt));
      end
    end
    checkOutput({tag, " pc"}, pc_out, exp_pc);
    checkOutput({tag, " retire_cnt"}, retire_cnt, 32'(exp_cnt));
    checkOutput({tag, " pulses"}, 32'(pulses), 32'(exp_cnt));
    checkOutput({tag, " writes"}, 32'(dut_wa.size()), 32'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size() && i < dut_wa.size(); i++) begin
      checkOutput({tag, " wr addr"}, dut_wa[i], exp_wa[i]);
      checkOutput({tag, " wr data"}, dut_wd[i], exp_wd[i]);
    end
    holdReset();
    checkOutput({tag, " rst halted"}, {31'd0, halted}, 32'd0);
    checkOutput({tag, " rst pc"}, pc_out, RESET_PC);
    checkOutput({tag, " rst state"}, {29'd0, state_out}, 32'd0);
  endtask

  task automatic gen_random();
    int n, kind, off;
    logic [5:0] fn;
    fill_memory();
    n = 20 + $urandom_range(0, 10);
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: emit(enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)), 16'($urandom)));
        1: begin
          case ($urandom_range(0, 4))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; default: fn = 6'h2A;
          endcase
          emit(enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), fn));
        end
        2: emit(enc_i(6'h2B, 5'd0, 5'($urandom_range(0, 7)), 16'(32'h200 + 4 * $urandom_range(0, 127))));
        3: emit(enc_i(6'h23, 5'd0, 5'($urandom_range(1, 7)), 16'(32'h200 + 4 * $urandom_range(0, 127))));
        4: begin
          off = $urandom_range(0, 3);
          emit(enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 16'(off)));
        end
        default: emit(enc_i(6'h08, 5'd0, 5'($urandom_range(1, 7)), 16'($urandom_range(0, 3))));
      endcase
    end
    for (int r = 1; r < 8; r++) emit(enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h3C0 + 4 * r)));
    emit_halt();
  endtask

  // Memory model: wait states chosen per request, commit sampled just before the edge
  initial begin
    mem_ack = 1'b0; mem_rdata = 32'd0; busy = 0; wait_left = 0; pulses = 0;
    req_addr = 32'd0; req_wdata = 32'd0; req_we = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!busy) begin
          busy = 1; req_addr = mem_addr; req_we = mem_we; req_wdata = mem_wdata;
          wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, max_wait);
        end else begin
          checkOutput("hold addr", mem_addr, req_addr);
          checkOutput("hold we", {31'd0, mem_we}, {31'd0, req_we});
          if (req_we) checkOutput("hold wdata", mem_wdata, req_wdata);
        end
        if (wait_left == 0) begin
          mem_ack = 1'b1; mem_rdata = mem[mem_addr[9:2]];
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom; wait_left--;
        end
      end else begin
        if (busy && rst === 1'b1) checkOutput("req held", {31'd0, mem_req}, 32'd1);
        busy = 0; mem_ack = 1'b0;
      end
      #4;
      if (instr_retired === 1'b1) pulses++;
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
        if (mem_we === 1'b1) begin
          mem[mem_addr[9:2]] = mem_wdata;
          dut_wa.push_back(mem_addr); dut_wd.push_back(mem_wdata);
        end
        busy = 0;
      end
    end
  end

  // Directed sequence followed by randomized programs
  initial begin
    logic [31:0] saved;
    int n;
    rst = 1'b0; rst4 = 1'b0;
    tick(2);
    checkOutput("reset pc", pc_out, RESET_PC);
    checkOutput("reset state", {29'd0, state_out}, 32'd0);
    checkOutput("reset cnt", retire_cnt, 32'd0);
    checkOutput("reset halted", {31'd0, halted}, 32'd0);
    checkOutput("reset req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset retire", {31'd0, instr_retired}, 32'd0);

    fill_memory();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h0200));
    emit_halt();
    applyStimulus("addi");
    tick(3);
    checkOutput("addi early", 32'(pulses), 32'd0);
    tick(1);
    checkOutput("addi pulse", 32'(pulses), 32'd1);
    checkOutput("addi cnt", retire_cnt, 32'd1);
    checkOutput("addi pc", pc_out, 32'h104);
    finishRun("addi", 200);

    fill_memory();
    mem[1] = 32'hDEAD_BEEF;
    emit(enc_i(6'h23, 5'd0, 5'd2, 16'd4));
    emit(enc_i(6'h2B, 5'd0, 5'd2, 16'h0200));
    emit_halt();
    fixed_wait = 2;
    applyStimulus("lw wait");
    tick(8);
    checkOutput("lw early", 32'(pulses), 32'd0);
    tick(1);
    checkOutput("lw pulse", 32'(pulses), 32'd1);
    finishRun("lw wait", 300);
    fixed_wait = -1;

    for (int k = 0; k < 2; k++) begin
      fill_memory();
      emit(enc_i(6'h08, 5'd0, 5'd1, 16'd7));
      emit(enc_i(6'h08, 5'd0, 5'd3, 16'd7));
      emit(enc_i((k == 0) ? 6'h04 : 6'h05, 5'd1, 5'd3, 16'd2));
      emit(enc_i(6'h08, 5'd0, 5'd5, 16'd1));
      emit(enc_i(6'h08, 5'd0, 5'd6, 16'd1));
      emit(enc_i(6'h2B, 5'd0, 5'd5, 16'h0200));
      emit(enc_i(6'h2B, 5'd0, 5'd6, 16'h0204));
      emit_halt();
      applyStimulus("branch");
      tick(11);
      checkOutput("branch pc", pc_out, (k == 0) ? 32'h114 : 32'h10C);
      checkOutput("branch pulses", 32'(pulses), 32'd3);
      finishRun("branch", 300);
    end

    fill_memory();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd3));
    emit(enc_r(5'd1, 5'd1, 5'd0, 6'h20));
    emit(enc_i(6'h2B, 5'd0, 5'd0, 16'h0200));
    emit_halt();
    applyStimulus("r0 write");
    tick(8);
    checkOutput("r0 pulses", 32'(pulses), 32'd2);
    finishRun("r0 write", 200);

    fill_memory();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd9));
    emit(32'hFC00_0000);
    applyStimulus("illegal op");
    finishRun("illegal op", 100);

    fill_memory();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'd1));
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'd6));
    applyStimulus("misaligned sw");
    finishRun("misaligned sw", 100);

    max_wait = 2;
    for (int t = 0; t < 6; t++) begin
      gen_random();
      applyStimulus("random");
      finishRun("random", 3000);
    end
    max_wait = 0;

    fill_memory();
    emit(enc_i(6'h08, 5'd0, 5'd1, 16'h0055));
    emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h0204));
    emit_halt();
    saved = mem[129];
    fixed_wait = 6;
    applyStimulus("reset in sw");
    n = 0;
    while (state_out !== 3'd3 && n < 40) begin tick(1); n++; end
    checkOutput("sw reached memacc", {29'd0, state_out}, 32'd3);
    tick(1);
    checkOutput("sw we", {31'd0, mem_we}, 32'd1);
    rst = 1'b0;
    tick(1);
    checkOutput("sw dropped req", {31'd0, mem_req}, 32'd0);
    checkOutput("sw rst pc", pc_out, RESET_PC);
    tick(10);
    checkOutput("sw no write", 32'(dut_wa.size()), 32'd0);
    checkOutput("sw mem kept", mem[129], saved);
    fixed_wait = -1;

    tick(1);
    checkOutput("wrap reset", {28'd0, cnt4}, 32'd0);
    rst4 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(3);
      checkOutput("wrap cnt", {28'd0, cnt4}, 32'(k % 16));
    end
    rst4 = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
